mips_register_file: RTL and testbench
=====================================

Name: mips_register_file

Overview:
- Parametrised successor of the single hardwired-zero register.
- A 2^a-entry × n-bit general-purpose register file for the MIPS datapath.
- Entry 0 is the hardwired zero register.
- Two combinational read ports, one synchronous write port.
- Per-register pending-write scoreboard (busy bits) so the decode stage can stall on outstanding load/multi-cycle results.

Parameters:
n, 32, data width of every register in bits
a, 5, address width; number of registers = 2^a

Ports:
clk_port  input  1  clock; all state updates on rising edge
rst_port  input  1  reset, synchronous, active-high
ra_port  input  a  read address, port A (rs)
rb_port  input  a  read address, port B (rt)
qa_port  output  n  read data, port A
qb_port  output  n  read data, port B
wa_port  input  a  write address
d_port  input  n  write data
en_port  input  1  write enable
busy_set_port  input  1  mark register busy_addr_port as pending-write
busy_addr_port  input  a  register to mark busy
busy_a_port  output  1  pending flag of register ra_port
busy_b_port  output  1  pending flag of register rb_port

Behaviour:
- Reset: rst_port=1 at a rising edge clears all registers to 0 and all busy bits to 0.
  - Reset has priority over en_port and busy_set_port in the same cycle.
  - Reset mid-operation discards any pending state.
- Outputs are combinational from state, so after reset qa/qb = 0 and busy_a/busy_b = 0.
- Read:
  - qa_port = reg[ra_port], qb_port = reg[rb_port], combinational, zero-cycle latency.
  - Address 0 always reads 0, on both ports, regardless of history.
- Write:
  - en_port=1 at a rising edge loads reg[wa_port] <= d_port.
  - Without the bypass feature the new value is visible on the read ports in the cycle after the edge.
  - A write to address 0 is ignored; reg 0 has no storage (constant 0).
- Scoreboard:
  - busy_set_port=1 at an edge sets busy[busy_addr_port].
  - en_port=1 at an edge clears busy[wa_port].
  - Same address set and written in one cycle: set wins, busy stays 1 (a new producer was issued as the old result retired). The written data is still stored.
  - Writing a register that is not busy is legal; busy stays 0.
  - busy[0] is constant 0; a busy_set to address 0 is ignored.
  - Setting an already-busy register leaves it busy (no counting; one outstanding producer per register).
- busy_a_port = busy[ra_port], busy_b_port = busy[rb_port], combinational.
- Port A and port B are fully independent.
  - Both may address the same register and return identical data and flags.
- All arithmetic is unsigned address decoding; no wrap-around beyond 2^a entries exists by construction.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through forwarding.
  - When en_port=1 and wa_port==ra_port!=0 in the same cycle, qa_port = d_port combinationally, and busy_a_port = 0 unless busy_set_port=1 with busy_addr_port==ra_port in that cycle.
  - Same rule for port B.
  - Address 0 is never forwarded; it still reads 0.
- Not defined: reads always return the stored value and stored busy bit; a same-cycle write is visible only after the edge.
- Storage, write and scoreboard behaviour are identical in both builds.

Test Plan:
- Reset then read: rst_port=1 for 1 cycle, then ra=3, rb=31 -> qa=0, qb=0, busy_a=0, busy_b=0.
- Write/read: write 0xDEADBEEF to r5, next cycle ra=rb=5 -> qa=qb=0xDEADBEEF. Same-cycle read of r5 during the write:
  - -> old value without REGFILE_BYPASS_EN;
  - -> 0xDEADBEEF with it.
- Zero register: en=1, wa=0, d=0xFFFFFFFF; also busy_set to addr 0 -> qa(ra=0)=0 and busy_a=0 forever after, in both builds.
- Scoreboard lifecycle:
  - busy_set r7 -> busy_a(ra=7)=1 next cycle.
  - Write r7=0x12 -> busy cleared next cycle, qa=0x12.
  - Simultaneous busy_set r7 and write r7=0x34 -> busy stays 1, qa=0x34.
- Reset priority: rst_port=1 with en=1, wa=9, d=0x55 and busy_set r9 -> next cycle qa(ra=9)=0, busy_a=0.
- Dual-port independence: r1=0xA, r2=0xB, busy r2 only; ra=1, rb=2 -> qa=0xA, qb=0xB, busy_a=0, busy_b=1. Swapping addresses swaps all four outputs.

Source files
------------

// File: rtl/mips_register_file.sv
// 2^a x n-bit MIPS register file: r0 hardwired to zero, two combinational read ports,
// one synchronous write port, per-register pending-write busy bits. Optional macro: REGFILE_BYPASS_EN.
module mips_register_file #(
    parameter int n = 32,
    parameter int a = 5
) (
    input  logic         clk_port,
    input  logic         rst_port,
    input  logic [a-1:0] ra_port,
    input  logic [a-1:0] rb_port,
    output logic [n-1:0] qa_port,
    output logic [n-1:0] qb_port,
    input  logic [a-1:0] wa_port,
    input  logic [n-1:0] d_port,
    input  logic         en_port,
    input  logic         busy_set_port,
    input  logic [a-1:0] busy_addr_port,
    output logic         busy_a_port,
    output logic         busy_b_port
);

    localparam int NREG = 1 << a;

    // Entry 0 exists in the array but is never written after reset, and reads of it are forced to 0.
    logic [n-1:0]    r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [n-1:0]    w_qa;
    logic [n-1:0]    w_qb;
    logic            w_busy_a;
    logic            w_busy_b;

    // Scoreboard next-state: a retiring write clears, a newly issued producer sets (set wins).
    always_comb begin
        w_busy_next = r_busy;
        if (en_port) begin
            w_busy_next[wa_port] = 1'b0;
        end else begin
            w_busy_next = w_busy_next;
        end
        if (busy_set_port) begin
            w_busy_next[busy_addr_port] = 1'b1;
        end else begin
            w_busy_next = w_busy_next;
        end
        w_busy_next[0] = 1'b0;
    end

    // Register storage and busy bits; reset overrides any same-cycle write or busy set.
    always_ff @(posedge clk_port) begin
        if (rst_port) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {n{1'b0}};
            end
            r_busy <= {NREG{1'b0}};
        end else begin
            if (en_port && (wa_port != {a{1'b0}})) begin
                r_regs[wa_port] <= d_port;
            end
            r_busy <= w_busy_next;
        end
    end

    // Read port A, with optional write-through forwarding of the same-cycle write.
    always_comb begin
        w_qa     = {n{1'b0}};
        w_busy_a = 1'b0;
        if (ra_port == {a{1'b0}}) begin
            w_qa     = {n{1'b0}};
            w_busy_a = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (en_port && (wa_port == ra_port)) begin
            w_qa     = d_port;
            w_busy_a = busy_set_port && (busy_addr_port == ra_port);
        end
`endif
        else begin
            w_qa     = r_regs[ra_port];
            w_busy_a = r_busy[ra_port];
        end
    end

    // Read port B, independent of port A.
    always_comb begin
        w_qb     = {n{1'b0}};
        w_busy_b = 1'b0;
        if (rb_port == {a{1'b0}}) begin
            w_qb     = {n{1'b0}};
            w_busy_b = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (en_port && (wa_port == rb_port)) begin
            w_qb     = d_port;
            w_busy_b = busy_set_port && (busy_addr_port == rb_port);
        end
`endif
        else begin
            w_qb     = r_regs[rb_port];
            w_busy_b = r_busy[rb_port];
        end
    end

    assign qa_port     = w_qa;
    assign qb_port     = w_qb;
    assign busy_a_port = w_busy_a;
    assign busy_b_port = w_busy_b;

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: a driver pushes model-predicted read results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_register_file;

    logic        clk = 1'b0;
    logic        rst_port = 1'b0;
    logic [4:0]  ra_port = 5'd0, rb_port = 5'd0, wa_port = 5'd0, busy_addr_port = 5'd0;
    logic [31:0] d_port = 32'd0;
    logic        en_port = 1'b0, busy_set_port = 1'b0;
    logic [31:0] qa_port, qb_port;
    logic        busy_a_port, busy_b_port;

    int total = 0;
    int bad   = 0;
    int step  = 0;

    typedef struct packed {
        logic [31:0] qa;
        logic [31:0] qb;
        logic        ba;
        logic        bb;
        logic [15:0] id;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    mips_register_file #(.n(32), .a(5)) dut (
        .clk_port(clk), .rst_port(rst_port),
        .ra_port(ra_port), .rb_port(rb_port),
        .qa_port(qa_port), .qb_port(qb_port),
        .wa_port(wa_port), .d_port(d_port), .en_port(en_port),
        .busy_set_port(busy_set_port), .busy_addr_port(busy_addr_port),
        .busy_a_port(busy_a_port), .busy_b_port(busy_b_port)
    );

    function automatic void check(string nm, int id, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, id, got, want);
        end
    endfunction

    // What a read of register r should show given the inputs currently applied.
    function automatic void predict(input logic [4:0] r, output logic [31:0] q, output logic b);
        if (r == 5'd0) begin
            q = 32'd0; b = 1'b0;
        end else begin
            q = m_mem[r]; b = m_busy[r];
`ifdef REGFILE_BYPASS_EN
            if (en_port && wa_port == r) begin
                q = d_port;
                b = busy_set_port && (busy_addr_port == r);
            end
`endif
        end
    endfunction

    task automatic drive(input bit chk, input logic rst, input logic en, input logic bs,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wa,
                         input logic [4:0] ba, input logic [31:0] d);
        exp_t e;
        rst_port = rst; en_port = en; busy_set_port = bs;
        ra_port = ra; rb_port = rb; wa_port = wa; busy_addr_port = ba; d_port = d;
        if (chk) begin
            predict(ra, e.qa, e.ba);
            predict(rb, e.qb, e.bb);
            e.id = 16'(step);
            sb_q.push_back(e);
        end
        step++;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_mem[i] = 32'd0; m_busy[i] = 1'b0; end
        end else begin
            if (en && wa != 5'd0) m_mem[wa] = d;
            if (en) m_busy[wa] = 1'b0;
            if (bs) m_busy[ba] = 1'b1;
            m_busy[0] = 1'b0;
        end
        #1;
    endtask

    // Monitor: outputs are combinational, so one expectation is due every cycle it is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("qa", int'(e.id), qa_port, e.qa);
                check("qb", int'(e.id), qb_port, e.qb);
                check("busy_a", int'(e.id), {31'd0, busy_a_port}, {31'd0, e.ba});
                check("busy_b", int'(e.id), {31'd0, busy_b_port}, {31'd0, e.bb});
            end
        end
    end

    initial begin
        logic [4:0] ra, rb, wa, ba;
        for (int i = 0; i < 32; i++) begin m_mem[i] = 32'd0; m_busy[i] = 1'b0; end
        @(posedge clk); #1;
        // reset, then read
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd31, 5'd0, 5'd0, 32'd0);
        // write r5 with same-cycle read, then read back
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 5'd0, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 5'd0, 32'd0);
        // zero register
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        // scoreboard lifecycle on r7
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd7, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 5'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 5'd0, 32'h12);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 5'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 5'd7, 32'h34);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 5'd0, 32'd0);
        // reset priority
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 32'h55);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 5'd0, 32'd0);
        // dual-port independence and swap
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd1, 5'd0, 32'hA);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd2, 5'd2, 32'hB);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 5'd1, 5'd0, 5'd0, 32'd0);
        // randomized traffic, addresses biased toward a small set to provoke collisions
        for (int k = 0; k < 3000; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            wa = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 5));
            ba = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 5));
            drive(1'b1, ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), ra, rb, wa, ba, $urandom());
        end
        en_port = 1'b0; busy_set_port = 1'b0; rst_port = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("drain", step, 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
